// File: rtl/uart_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_pkg
// Shared definitions for the UART/IR transmit scheduler: FSM state encoding
// and the indices of the two byte sources that compete for the transmitter.
// -----------------------------------------------------------------------------
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request; the only state that samples req*
    LOAD = 2'd1,  // one-cycle start/ack strobe
    WAIT = 2'd2,  // frame in flight, watchdog running
    GAP  = 2'd3   // enforced idle time between frames
  } state_e;

  localparam logic REQ_SW   = 1'b0;  // manual switch/button send
  localparam logic REQ_ECHO = 1'b1;  // auto-echo of received bytes

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. The winner is combinational from the request
// lines and the priority pointer; the pointer moves only on an update strobe,
// so a grant that never reaches LOAD leaves priority untouched.
//
// Ports:
//   clock_i   system clock
//   reset_i   synchronous active-low reset (pointer -> REQ_SW)
//   req0_i    request from requester 0
//   req1_i    request from requester 1
//   upd_i     pointer update strobe
//   last_i    requester that was just served; pointer becomes ~last_i
//   grant_o   at least one request is active
//   winner_o  index of the winning requester (valid when grant_o)
// -----------------------------------------------------------------------------
module rr_arbiter2
  import uart_tx_scheduler_pkg::*;
(
  input  logic clock_i,
  input  logic reset_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic last_i,
  output logic grant_o,
  output logic winner_o
);

  logic rr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // in the design updates from the same pre-edge values.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      rr_q <= REQ_SW;
    end else if (upd_i) begin
      rr_q <= ~last_i;
    end
  end

  // NOTE: both outputs are assigned on every path, so no latch is inferred.
  always_comb begin
    grant_o  = req0_i | req1_i;
    winner_o = (req0_i && req1_i) ? rr_q : req1_i;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares the single UART/IR transmit path between the switch sender (req0)
// and the receive auto-echo (req1). Arbitrates round-robin, loads the winning
// byte, waits for tx_done with a baud-tick watchdog, then enforces an
// inter-frame gap before the next grant.
//
// Ports:
//   clock_i        system clock
//   reset_i        synchronous active-low reset
//   baud_i         one-cycle baud tick
//   req0_i/data0_i requester 0 request (held until ack0) and byte
//   req1_i/data1_i requester 1 request (held until ack1) and byte
//   tx_done_i      one-cycle pulse: frame finished
//   ack0_o/ack1_o  one-cycle pulse: corresponding data captured
//   tx_data_o      byte for the parity generator / sender shift register
//   tx_start_o     one-cycle pulse: load and start the frame
//   busy_o         high in any state other than IDLE
//   owner_o        requester of the current or last frame
//   timeout_err_o  sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       baud_i,
  input  logic       req0_i,
  input  logic [7:0] data0_i,
  input  logic       req1_i,
  input  logic [7:0] data1_i,
  input  logic       tx_done_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  output logic       busy_o,
  output logic       owner_o,
  output logic       timeout_err_o
);

  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_TICKS);
  localparam bit               NO_GAP  = (GAP_TICKS == 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       tx_data_q;
  logic             owner_q;
  logic             tx_start_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             busy_q;
  logic             timeout_err_q;
  logic             grant;
  logic             winner;

  rr_arbiter2 u_arb (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .req0_i   (req0_i),
    .req1_i   (req1_i),
    .upd_i    (state_q == LOAD),
    .last_i   (owner_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock_i) begin
    // NOTE: the reset is sampled on the clock edge like any other input, so
    // it sits inside the clocked block rather than in the sensitivity list.
    if (!reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      owner_q       <= REQ_SW;
      tx_start_q    <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // Strobes default low so that they are high for the LOAD cycle only.
      tx_start_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant) begin
            tx_data_q  <= winner ? data1_i : data0_i;
            owner_q    <= winner;
            tx_start_q <= 1'b1;
            ack0_q     <= (winner == REQ_SW);
            ack1_q     <= (winner == REQ_ECHO);
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end

        LOAD: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end

        WAIT: begin
          // tx_done has priority over a coincident timeout tick.
          if (tx_done_i) begin
            cnt_q   <= '0;
            state_q <= GAP;
          end else if (baud_i) begin
            if (cnt_inc >= TO_LIM) begin
              timeout_err_q <= 1'b1;
              cnt_q         <= '0;
              state_q       <= GAP;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        GAP: begin
          if (NO_GAP) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (baud_i) begin
            if (cnt_inc >= GAP_LIM) begin
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign ack0_o        = ack0_q;
  assign ack1_o        = ack1_q;
  assign busy_o        = busy_q;
  assign owner_o       = owner_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench: a table of arbitration vectors, hand-written corner
// sequences (back-to-back, timeout, coincident done, reset mid-frame, dropped
// request, zero gap) and randomized frames checked against a transaction-level
// model (round-robin pointer, sticky error flag, tick counting).
// Inputs are driven on the falling edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int GAP = 2;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n, baud, req0, req1, tx_done;
  logic [7:0] data0, data1;

  logic       m_ack0, m_ack1, m_tx_start, m_busy, m_owner, m_err;
  logic [7:0] m_tx_data;
  logic       g_ack0, g_ack1, g_tx_start, g_busy, g_owner, g_err;
  logic [7:0] g_tx_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO), .CNT_W(5)) dut (
    .clock_i(clk), .reset_i(rst_n), .baud_i(baud),
    .req0_i(req0), .data0_i(data0), .req1_i(req1), .data1_i(data1),
    .tx_done_i(tx_done), .ack0_o(m_ack0), .ack1_o(m_ack1),
    .tx_data_o(m_tx_data), .tx_start_o(m_tx_start), .busy_o(m_busy),
    .owner_o(m_owner), .timeout_err_o(m_err)
  );

  // Second instance with no inter-frame gap; shares all inputs.
  uart_tx_scheduler #(.GAP_TICKS(0), .TIMEOUT_TICKS(TMO), .CNT_W(5)) dut_g0 (
    .clock_i(clk), .reset_i(rst_n), .baud_i(baud),
    .req0_i(req0), .data0_i(data0), .req1_i(req1), .data1_i(data1),
    .tx_done_i(tx_done), .ack0_o(g_ack0), .ack1_o(g_ack1),
    .tx_data_o(g_tx_data), .tx_start_o(g_tx_start), .busy_o(g_busy),
    .owner_o(g_owner), .timeout_err_o(g_err)
  );

  typedef struct {
    bit         r0;
    bit         r1;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         exp_owner;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  // Model state for the randomized section.
  bit rr_m;
  bit err_m;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive baud/tx_done for this edge, return at the next falling edge.
  task automatic cyc(input logic b, input logic d);
    // NOTE: bench stimulus uses blocking assignments away from the active edge.
    baud    = b;
    tx_done = d;
    @(posedge clk);
    @(negedge clk);
    baud    = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    req0  = 1'b0;
    req1  = 1'b0;
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    rr_m  = 1'b0;
    err_m = 1'b0;
  endtask

  // Requests are already driven and the DUT is idle: expect the grant strobes
  // on the next edge, then their removal on the one after.
  task automatic grant_check(input bit who, input logic [7:0] d, input bit keep);
    cyc(1'b0, 1'b0);
    check1("tx_start", m_tx_start, 1'b1);
    check1("ack0", m_ack0, !who);
    check1("ack1", m_ack1, who);
    check8("tx_data", m_tx_data, d);
    check1("owner", m_owner, who);
    check1("busy_load", m_busy, 1'b1);
    if (!keep) begin
      if (who) req1 = 1'b0;
      else     req0 = 1'b0;
    end
    cyc(1'b0, 1'b0);
    check1("start_pulse_end", m_tx_start, 1'b0);
    check1("ack_pulse_end", m_ack0 | m_ack1, 1'b0);
    check8("tx_data_hold", m_tx_data, d);
  endtask

  // Frame in flight: tx_done after n baud ticks (or with tick n when coinc);
  // 'to' reports whether the watchdog should have fired first.
  task automatic wait_phase(input int n, input bit coinc, output bit to);
    int k;
    k  = 0;
    to = 1'b0;
    while (1) begin
      if (k == n && !coinc) begin
        cyc(1'b0, 1'b1);
        return;
      end
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0);
      k++;
      if (k == n && coinc) begin
        cyc(1'b1, 1'b1);
        return;
      end
      cyc(1'b1, 1'b0);
      if (k == TMO) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  // GAP baud ticks with stray tx_done pulses in between; idle after the last.
  task automatic gap_phase();
    for (int k = 1; k <= GAP; k++) begin
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom_range(0, 1)));
      cyc(1'b1, 1'b0);
      if (k < GAP) check1("gap_busy", m_busy, 1'b1);
    end
    check1("gap_end_idle", m_busy, 1'b0);
    check1("gap_end_no_start", m_tx_start, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit         to;
    bit         win;
    bit         coinc;
    int         n;
    logic [7:0] exp_d;

    // Starting from reset the pointer favours requester 0.
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'hA5};
    tbl[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22};
    tbl[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 8'h33};
    tbl[3] = '{1'b1, 1'b0, 8'h55, 8'h66, 1'b0, 8'h55};
    tbl[4] = '{1'b1, 1'b1, 8'h77, 8'h88, 1'b1, 8'h88};
    tbl[5] = '{1'b0, 1'b1, 8'h99, 8'hAA, 1'b1, 8'hAA};
    tbl[6] = '{1'b1, 1'b1, 8'hBB, 8'hCC, 1'b0, 8'hBB};
    tbl[7] = '{1'b1, 1'b1, 8'hDE, 8'hAD, 1'b1, 8'hAD};

    rst_n = 1'b0; baud = 1'b0; tx_done = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    @(negedge clk);
    do_reset();

    check1("rst_tx_start", m_tx_start, 1'b0);
    check1("rst_ack0", m_ack0, 1'b0);
    check1("rst_ack1", m_ack1, 1'b0);
    check8("rst_tx_data", m_tx_data, 8'h00);
    check1("rst_busy", m_busy, 1'b0);
    check1("rst_owner", m_owner, 1'b0);
    check1("rst_err", m_err, 1'b0);

    // Table-driven arbitration vectors.
    for (int i = 0; i < 8; i++) begin
      req0 = tbl[i].r0; data0 = tbl[i].d0;
      req1 = tbl[i].r1; data1 = tbl[i].d1;
      grant_check(tbl[i].exp_owner, tbl[i].exp_data, 1'b0);
      req0 = 1'b0;
      req1 = 1'b0;
      wait_phase(2, 1'b0, to);
      check1("tbl_busy_wait_end", m_busy, 1'b1);
      gap_phase();
    end

    // Both held high, tx_done 10 ticks after each start: 11,22,11,22.
    do_reset();
    req0 = 1'b1; data0 = 8'h11;
    req1 = 1'b1; data1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      grant_check(1'(i % 2), (i % 2 == 1) ? 8'h22 : 8'h11, 1'b1);
      wait_phase(10, 1'b0, to);
      gap_phase();
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Watchdog: no tx_done, error exactly on the 16th tick.
    do_reset();
    req0 = 1'b1; data0 = 8'h3C;
    grant_check(1'b0, 8'h3C, 1'b0);
    repeat (TMO - 1) cyc(1'b1, 1'b0);
    check1("to_not_yet", m_err, 1'b0);
    check1("to_busy_before", m_busy, 1'b1);
    cyc(1'b1, 1'b0);
    check1("to_set", m_err, 1'b1);
    check1("to_busy_gap", m_busy, 1'b1);
    gap_phase();
    req1 = 1'b1; data1 = 8'h5A;
    grant_check(1'b1, 8'h5A, 1'b0);
    wait_phase(1, 1'b0, to);
    gap_phase();
    check1("to_sticky", m_err, 1'b1);

    // Reset mid-frame, then a late tx_done must be ignored.
    req1 = 1'b1; data1 = 8'h77;
    grant_check(1'b1, 8'h77, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    check1("mid_rst_start", m_tx_start, 1'b0);
    check1("mid_rst_ack", m_ack0 | m_ack1, 1'b0);
    check8("mid_rst_data", m_tx_data, 8'h00);
    check1("mid_rst_busy", m_busy, 1'b0);
    check1("mid_rst_owner", m_owner, 1'b0);
    check1("mid_rst_err", m_err, 1'b0);
    cyc(1'b0, 1'b1);
    check1("late_done_busy", m_busy, 1'b0);
    check1("late_done_start", m_tx_start, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    check1("late_done_idle", m_busy, 1'b0);
    check1("late_done_err", m_err, 1'b0);

    // tx_done coincident with the 16th tick: no error.
    do_reset();
    req0 = 1'b1; data0 = 8'hC0;
    grant_check(1'b0, 8'hC0, 1'b0);
    repeat (TMO - 1) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check1("coinc_no_err", m_err, 1'b0);
    check1("coinc_busy_gap", m_busy, 1'b1);

    // A request raised in GAP and dropped before IDLE is never served.
    req0 = 1'b1; data0 = 8'hEE;
    cyc(1'b1, 1'b0);
    req0 = 1'b0;
    cyc(1'b1, 1'b0);
    check1("drop_idle", m_busy, 1'b0);
    cyc(1'b0, 1'b0);
    check1("drop_no_start", m_tx_start, 1'b0);
    check1("drop_no_ack", m_ack0, 1'b0);
    check1("drop_still_idle", m_busy, 1'b0);

    // Randomized frames against the transaction-level model.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int t = 0; t < 14; t++) begin
        if (!req0 && $urandom_range(0, 1) == 1) begin
          req0 = 1'b1; data0 = 8'($urandom);
        end
        if (!req1 && $urandom_range(0, 1) == 1) begin
          req1 = 1'b1; data1 = 8'($urandom);
        end
        if (!req0 && !req1) begin
          if ($urandom_range(0, 1) == 1) begin
            req1 = 1'b1; data1 = 8'($urandom);
          end else begin
            req0 = 1'b1; data0 = 8'($urandom);
          end
        end
        win   = (req0 && req1) ? rr_m : req1;
        exp_d = win ? data1 : data0;
        grant_check(win, exp_d, 1'b0);
        rr_m  = ~win;
        n     = int'($urandom_range(0, 20));
        coinc = (n > 0) && ($urandom_range(0, 3) == 0);
        wait_phase(n, coinc, to);
        err_m = err_m | to;
        check1("rnd_err", m_err, err_m);
        check1("rnd_busy_gap", m_busy, 1'b1);
        gap_phase();
      end
    end

    // Zero-gap instance: tx_done sampled at edge T, GAP for one cycle, IDLE
    // for one cycle, and the held request restarts right after edge T+2.
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    req1 = 1'b1; data1 = 8'hC3;
    cyc(1'b0, 1'b0);
    check1("g0_first_start", g_tx_start, 1'b1);
    check1("g0_first_ack1", g_ack1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check1("g0_gap_no_start", g_tx_start, 1'b0);
    check1("g0_gap_busy", g_busy, 1'b1);
    cyc(1'b0, 1'b0);
    check1("g0_idle", g_busy, 1'b0);
    check1("g0_idle_no_start", g_tx_start, 1'b0);
    cyc(1'b0, 1'b0);
    check1("g0_restart", g_tx_start, 1'b1);
    check1("g0_restart_ack1", g_ack1, 1'b1);
    check8("g0_restart_data", g_tx_data, 8'hC3);
    req1 = 1'b0;
    cyc(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
